inst_cache: RTL
===============

# inst_cache

Direct-mapped, read-only instruction cache between the IF stage and the external instruction memory port. It serves IF fetches combinationally on a hit and drives `inst_cache_ready`, which the pipeline controller uses to generate its instruction-memory stall. On a miss it refills one 4-word line over a beat-serial memory interface. It also supports a whole-cache invalidate for `fence.i`.

## Interface
- `LINES`, 16: number of cache lines. Power of two, ≥2. `IDX_W = log2(LINES)`.
- `ADDR_W`, 32: fetch address width. Tag width `TAG_W = ADDR_W - 4 - IDX_W`.
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous, active-low.
- `F_im_r_en` input 1: IF fetch request.
- `F_pc` input ADDR_W: fetch address. Bits [1:0] are ignored.
- `invalidate` input 1: single-cycle pulse that requests clearing all valid bits.
- `F_inst` output 32: fetched instruction.
- `inst_cache_ready` output 1: fetch satisfied this cycle, or no fetch requested.
- `mem_req` output 1: refill request, held for the whole refill.
- `mem_addr` output ADDR_W: line-aligned refill address, bits [3:0] = 0.
- `mem_rvalid` input 1: one refill data beat is valid.
- `mem_rdata` input 32: refill beat data.

## Operation
- Address split:
  - offset = `F_pc[3:2]`
  - index = `F_pc[4+IDX_W-1:4]`
  - tag = `F_pc[ADDR_W-1:4+IDX_W]`
- Storage: per line, one valid bit, a tag, and 4 data words. Valid bits and the state are reset; tag and data contents are not.
- hit = state IDLE & valid[index] & (tag_array[index] == tag).
- `inst_cache_ready` = ~`F_im_r_en` | hit.
- `F_inst` = data[index][offset] when hit, else 32'h00000013 (NOP).
- FSM states: IDLE, REFILL, FLUSH.
  - **IDLE**
    - If `invalidate` is high, go to FLUSH. Invalidate has priority over a miss.
    - Else, if `F_im_r_en` & ~hit: latch {tag, index} into the refill registers, clear the beat counter, and go to REFILL.
  - **REFILL**
    - `mem_req`=1. `mem_addr` = {latched tag, latched index, 4'b0}, constant for the whole refill.
    - On each `mem_rvalid`, write `mem_rdata` to word[beat_cnt] of the latched line and increment the 2-bit beat_cnt.
    - On the beat with beat_cnt==3: write tag_array, set valid, drop `mem_req` at the next edge, and go to IDLE. If an invalidate is pending, go to FLUSH instead.
    - `invalidate` seen during REFILL sets flush_pending. The refill is never aborted.
  - **FLUSH**
    - Clear valid[flush_cnt] each cycle, with flush_cnt running 0..LINES-1.
    - After LINES-1, clear flush_pending and go to IDLE.
    - `invalidate` during FLUSH is ignored.
- `mem_rvalid` outside REFILL is ignored, with no state change.
- `F_pc` may change during REFILL or FLUSH. Lookup always uses the current `F_pc` once back in IDLE; a new miss starts a new refill.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE; all valid=0; flush_pending=0; beat_cnt=0; flush_cnt=0.
  - `mem_req`=0, `mem_addr`=0.
  - `F_inst`=NOP; `inst_cache_ready`=~`F_im_r_en`.
- Reset asserted mid-REFILL: `mem_req` falls immediately and the partial line stays invalid.
- Hit latency: 0 cycles. `F_inst` and ready are combinational from `F_pc` and registered state.
- Miss penalty: miss is seen in cycle t with ready=0. Cycle t+1: REFILL, `mem_req`=1. With beats at t+2..t+5, the line is valid after the t+5 edge and ready=1 in t+6.
- Memory may insert any number of idle cycles between beats. The cache waits indefinitely.
- FLUSH lasts exactly LINES cycles, with ready=0 whenever `F_im_r_en`=1.
- A miss and `invalidate` in the same IDLE cycle: FLUSH runs first, then the fetch misses and refills.
- A write to line i in the same cycle a lookup hits line j≠i cannot occur, because lookups only hit in IDLE.

## Test plan
- Cold fetch: reset, `F_im_r_en`=1, `F_pc`=0x100, memory returns 0xA0,0xA1,0xA2,0xA3 back-to-back → ready=0 for 6 cycles, `mem_addr`=0x100, then `F_inst`=0xA0 and ready=1. `F_pc`=0x10C then hits with 0xA3 in 0 cycles.
- Conflict: fill 0x100, then fetch 0x200 (LINES=16, same index) → refill at `mem_addr`=0x200. A return to 0x100 misses again.
- Gapped beats: 3 idle cycles between each `mem_rvalid` → `mem_req` held high and `mem_addr` stable throughout; ready rises exactly one cycle after the 4th beat.
- Invalidate: with 0x100 and 0x140 valid, pulse `invalidate` → ready=0 for 16 cycles with `F_im_r_en`=1; both addresses then miss.
- Invalidate during REFILL (after beat 1) → refill completes, FLUSH follows, and 0x100 misses afterwards.
- Reset mid-REFILL after beat 2 → `mem_req`=0 immediately; after release, 0x100 misses and refills all 4 beats.

Source files
------------

// File: rtl/inst_cache.sv
`default_nettype none
// ============================================================================
// Module   : inst_cache
// Purpose  : Direct-mapped read-only instruction cache, 4-word lines, serial
//            line refill from the instruction memory and a fence.i flush.
// Revision : 1.0
// ============================================================================
module inst_cache #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              F_im_r_en,
  input  logic [ADDR_W-1:0] F_pc,
  input  logic              invalidate,
  output logic [31:0]       F_inst,
  output logic              inst_cache_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;
  localparam logic [31:0]      C_NOP       = 32'h0000_0013;
  localparam logic [IDX_W-1:0] C_LAST_LINE = IDX_W'(LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic               flush_pending_q, flush_pending_d;
  logic [1:0]         beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [TAG_W-1:0]   ref_tag_q, ref_tag_d;
  logic [IDX_W-1:0]   ref_idx_q, ref_idx_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;

  // Tag and data storage carry no reset; the valid bits guard them.
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES][4];

  logic [1:0]         pc_off;
  logic [IDX_W-1:0]   pc_idx;
  logic [TAG_W-1:0]   pc_tag;
  logic               hit;
  logic               fill_beat;
  logic               fill_last;
  logic               unused_pc_bits;

  assign pc_off         = F_pc[3:2];
  assign pc_idx         = F_pc[4+IDX_W-1:4];
  assign pc_tag         = F_pc[ADDR_W-1:4+IDX_W];
  assign unused_pc_bits = ^F_pc[1:0];

  assign hit = (state_q == S_IDLE) && valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);

  assign inst_cache_ready = !F_im_r_en || hit;
  assign F_inst           = hit ? data_mem[pc_idx][pc_off] : C_NOP;
  assign mem_req          = mem_req_q;
  assign mem_addr         = mem_addr_q;

  assign fill_beat = (state_q == S_REFILL) && mem_rvalid;
  assign fill_last = fill_beat && (beat_cnt_q == 2'd3);

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    flush_pending_d = flush_pending_q;
    beat_cnt_d      = beat_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    ref_tag_d       = ref_tag_q;
    ref_idx_d       = ref_idx_q;
    mem_req_d       = mem_req_q;
    mem_addr_d      = mem_addr_q;

    case (state_q)
      S_IDLE: begin
        if (invalidate) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end else if (F_im_r_en && !hit) begin
          state_d    = S_REFILL;
          ref_tag_d  = pc_tag;
          ref_idx_d  = pc_idx;
          beat_cnt_d = 2'd0;
          mem_req_d  = 1'b1;
          mem_addr_d = {pc_tag, pc_idx, 4'b0000};
        end
      end

      S_REFILL: begin
        // A flush request never aborts the refill; it is remembered instead.
        if (invalidate) begin
          flush_pending_d = 1'b1;
        end
        if (fill_beat) begin
          beat_cnt_d = beat_cnt_q + 2'd1;
        end
        if (fill_last) begin
          valid_d[ref_idx_q] = 1'b1;
          mem_req_d          = 1'b0;
          if (flush_pending_q || invalidate) begin
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_FLUSH: begin
        valid_d[flush_cnt_q] = 1'b0;
        flush_cnt_d          = flush_cnt_q + 1'b1;
        if (flush_cnt_q == C_LAST_LINE) begin
          flush_pending_d = 1'b0;
          state_d         = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      beat_cnt_q      <= 2'd0;
      flush_cnt_q     <= '0;
      ref_tag_q       <= '0;
      ref_idx_q       <= '0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      flush_pending_q <= flush_pending_d;
      beat_cnt_q      <= beat_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      ref_tag_q       <= ref_tag_d;
      ref_idx_q       <= ref_idx_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_beat) begin
      data_mem[ref_idx_q][beat_cnt_q] <= mem_rdata;
    end
    if (fill_last) begin
      tag_mem[ref_idx_q] <= ref_tag_q;
    end
  end

endmodule
`default_nettype wire
